config_loader: RTL and testbench
================================

# config_loader

Configuration bitstream loader that sits directly upstream of the logic-element input interconnect's serial configuration chain. It accepts parallel configuration words from a host over a valid/ready handshake and serializes them MSB-first onto the chain's `config_en` / `config_data_in` pins. It counts exactly `CHAIN_LEN` bits, then signals completion with a one-cycle `done` pulse. It is the single driver of the chain head for one tile.

## Interface
- `CHAIN_LEN`, default 48: total configuration bits in the downstream chain (LE_INPUTS·4·3 for LE_INPUTS=4); ≥1.
- `WORD_W`, default 8: host word width in bits; ≥1.
- `clk`  input  1  single clock for the block and the chain.
- `nrst`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a load; sampled only in IDLE.
- `abort`  input  1  cancel any load in progress; has priority over everything except reset.
- `word_in`  input  WORD_W  configuration word; bit WORD_W-1 is shifted first.
- `word_valid`  input  1  `word_in` is valid.
- `word_ready`  output  1  the block accepts `word_in` this cycle.
- `config_en`  output  1  chain shift enable (registered).
- `config_data_out`  output  1  serial bit to the chain head (registered); meaningful only when `config_en`=1.
- `busy`  output  1  high in LOAD and SHIFT.
- `done`  output  1  one-cycle pulse when all CHAIN_LEN bits have been shifted.

## Operation
- States:
  - IDLE: waits for `start`.
  - LOAD: `word_ready`=1, waits for the handshake.
  - SHIFT: drives bits onto the chain.
  - DONE: `done`=1 for one cycle.
- Counters:
  - `bit_cnt`: bits shifted this load, width $clog2(CHAIN_LEN+1).
  - `sh_cnt`: bits remaining in the current word, width $clog2(WORD_W+1).
- IDLE → LOAD when `start`=1. Entering LOAD from IDLE clears `bit_cnt`.
- LOAD: when `word_valid`=1, the word is transferred. The block captures `word_in` into a shift register and loads `sh_cnt` = min(WORD_W, CHAIN_LEN − `bit_cnt`). The next state is SHIFT.
- SHIFT, every cycle:
  - `config_en`=1 and `config_data_out` = shift register MSB.
  - The shift register shifts left, `sh_cnt` decrements and `bit_cnt` increments.
- At the last bit of a word (`sh_cnt`=1): go to DONE if `bit_cnt`+1 = CHAIN_LEN, otherwise to LOAD.
- Partial final word: only its top (CHAIN_LEN mod WORD_W) bits are shifted. The remaining low bits are discarded.
- Bit order: the first bit shifted ends at chain position CHAIN_LEN-1. The last bit shifted ends at position 0.
- DONE → IDLE unconditionally after one cycle.
- `start` outside IDLE is ignored.
- `abort`=1 in any state:
  - Next state is IDLE and `config_en` is 0 from the next cycle.
  - `done` is not pulsed and any pending word is dropped.
  - The chain keeps whatever bits were already shifted.
  - `abort` together with `start` in IDLE stays in IDLE.
- `word_ready` = (state==LOAD) & ~`abort`.
- Data on `word_in` is ignored unless `word_valid`=1 and `word_ready`=1.

## Timing
- Reset values: state=IDLE, `config_en`=0, `config_data_out`=0, `word_ready`=0, `busy`=0, `done`=0, both counters 0, shift register 0.
- Reset asserted mid-load returns everything to the reset values immediately (asynchronous). No further chain shifts occur.
- `start` sampled at edge N → LOAD, with `word_ready`=1, from cycle N+1.
- Handshake at edge M → `config_en`=1 from cycle M+1 for k cycles, where k = bits in that word.
- After the last shift cycle, `config_en`=0 for at least one cycle: either the LOAD cycle or the DONE cycle. There is no back-to-back word acceptance.
- With `word_valid` held high, each word costs WORD_W+1 cycles.
- Full load latency from `start` edge to `done` = ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN + 1 cycles.
- `done` is high for exactly one cycle. `busy` is low during DONE.
- `word_valid` may drop in LOAD indefinitely; the block waits with `config_en`=0.

## Test plan
- Reset with `word_valid`=1 and `start`=1 while `nrst`=0 → all outputs 0. No `config_en` until `start` is seen after reset release.
- CHAIN_LEN=48, WORD_W=8, six words 0xA5,0x3C,0xFF,0x00,0x81,0x7E with `word_valid` always 1:
  - `config_en` is high in 6 bursts of 8 cycles.
  - The downstream 48-bit chain model reads 0xA53CFF00817E.
  - `done` pulses once, 55 cycles after the `start` edge.
- CHAIN_LEN=12, WORD_W=8, words 0xC3 then 0x9F:
  - Exactly 12 `config_en` cycles.
  - Chain = 0xC39 and the low nibble 0xF is never shifted.
  - `done` after 15 cycles.
- Host stalls: `word_valid` low for 5 cycles in each LOAD → `config_en` stays 0 during each stall. Final chain contents are identical to the no-stall run.
- `abort` during the 3rd SHIFT cycle of word 2:
  - `config_en`=0 from the next cycle and `done` is never asserted.
  - The block returns to IDLE.
  - A subsequent `start` performs a complete, correct load.
- `start` pulsed during SHIFT and during DONE → ignored, and no second load begins.

Source files
------------

// File: rtl/config_loader.sv
// config_loader: serializes host configuration words MSB-first onto a serial
// configuration chain, counting exactly CHAIN_LEN bits and then pulsing done.
//
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   start            begin a load (sampled only in IDLE)
//   abort            cancel any load in progress (priority over all but reset)
//   word_in          host configuration word, bit WORD_W-1 shifted first
//   word_valid       word_in is valid
//   word_ready       word accepted this cycle when word_valid is also high
//   config_en        registered chain shift enable
//   config_data_out  registered serial bit to the chain head
//   busy             high while loading or shifting
//   done             one-cycle completion pulse
module config_loader #(
  parameter int unsigned CHAIN_LEN = 48,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              config_en,
  output logic              config_data_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BitW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned ShW  = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ShW-1:0]    sh_cnt_q, sh_cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              en_q, en_d;
  logic              dout_q, dout_d;

  logic [31:0]       remaining;
  logic [ShW-1:0]    sh_load;
  logic [WORD_W-1:0] shifted;
  logic              last_bit;
  logic              chain_end;

  // Bits left in the chain decide how much of the next word is used; a short
  // final word only contributes its top bits.
  assign remaining = CHAIN_LEN - 32'(bit_cnt_q);
  assign sh_load   = (remaining > 32'(WORD_W)) ? ShW'(WORD_W) : ShW'(remaining);
  assign shifted   = shreg_q << 1;
  assign last_bit  = (sh_cnt_q == ShW'(1));
  assign chain_end = ((32'(bit_cnt_q) + 32'd1) == CHAIN_LEN);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_cnt_d  = sh_cnt_q;
    shreg_d   = shreg_q;
    en_d      = 1'b0;
    dout_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          bit_cnt_d = '0;
        end
      end
      StLoad: begin
        if (word_valid) begin
          shreg_d  = word_in;
          sh_cnt_d = sh_load;
          // Outputs are registered, so the first bit is presented as we enter SHIFT.
          en_d     = 1'b1;
          dout_d   = word_in[WORD_W-1];
          state_d  = StShift;
        end
      end
      StShift: begin
        shreg_d   = shifted;
        sh_cnt_d  = sh_cnt_q - ShW'(1);
        bit_cnt_d = bit_cnt_q + BitW'(1);
        if (last_bit) begin
          state_d = chain_end ? StDone : StLoad;
        end else begin
          en_d   = 1'b1;
          dout_d = shifted[WORD_W-1];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort drops any pending word and leaves the chain as already shifted.
    if (abort) begin
      state_d   = StIdle;
      bit_cnt_d = bit_cnt_q;
      sh_cnt_d  = sh_cnt_q;
      shreg_d   = shreg_q;
      en_d      = 1'b0;
      dout_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      sh_cnt_q  <= '0;
      shreg_q   <= '0;
      en_q      <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_cnt_q  <= sh_cnt_d;
      shreg_q   <= shreg_d;
      en_q      <= en_d;
      dout_q    <= dout_d;
    end
  end

  assign word_ready      = (state_q == StLoad) & ~abort;
  assign busy            = (state_q == StLoad) | (state_q == StShift);
  assign done            = (state_q == StDone);
  assign config_en       = en_q;
  assign config_data_out = dout_q;

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: DUT 0 has CHAIN_LEN=48, DUT 1 has
// CHAIN_LEN=12, both WORD_W=8. Stimulus pushes the expected chain contents,
// shift count and start-to-done latency; a negedge monitor models the
// downstream chain and pops/compares on every done pulse.
module tb_config_loader;

  logic       clk;
  logic       nrst;
  logic [1:0] start_s, abort_s, valid_s;
  logic [1:0] ready_s, en_s, dout_s, busy_s, done_s;
  logic [7:0] win_s [2];

  config_loader #(.CHAIN_LEN(48), .WORD_W(8)) u_dut0 (
    .clk(clk), .nrst(nrst), .start(start_s[0]), .abort(abort_s[0]),
    .word_in(win_s[0]), .word_valid(valid_s[0]), .word_ready(ready_s[0]),
    .config_en(en_s[0]), .config_data_out(dout_s[0]), .busy(busy_s[0]),
    .done(done_s[0])
  );

  config_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_dut1 (
    .clk(clk), .nrst(nrst), .start(start_s[1]), .abort(abort_s[1]),
    .word_in(win_s[1]), .word_valid(valid_s[1]), .word_ready(ready_s[1]),
    .config_en(en_s[1]), .config_data_out(dout_s[1]), .busy(busy_s[1]),
    .done(done_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    logic [63:0] chain;
    int          en;
    int          lat;
  } exp_t;

  exp_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  wbuf [8];
  logic [63:0] chain_m [2];
  int          en_cnt [2];
  int          lat_cnt [2];

  function automatic int cl_of(input int d);
    return (d == 0) ? 48 : 12;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: the chain holds the first CHAIN_LEN bits of the word stream,
  // first bit at the top.
  function automatic logic [63:0] ref_chain(input int cl, input int nw);
    logic [63:0] ch = '0;
    int          n  = 0;
    for (int i = 0; i < nw; i++) begin
      for (int b = 7; b >= 0; b--) begin
        if (n < cl) begin
          ch = {ch[62:0], wbuf[i][b]};
          n++;
        end
      end
    end
    return ch;
  endfunction

  // Monitor: downstream chain model plus scoreboard comparison.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ready_s[d]) chk($sformatf("en_in_load%0d", d), 64'(en_s[d]), 64'd0);
      if (en_s[d]) begin
        chain_m[d] = {chain_m[d][62:0], dout_s[d]};
        en_cnt[d]++;
      end
      if (busy_s[d]) lat_cnt[d]++;
      if (done_s[d]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done%0d: got done=1, expected no pulse (t=%0t)", d, $time);
        end else begin
          exp_t        e;
          logic [63:0] mask;
          e    = exp_q.pop_front();
          mask = (64'd1 << cl_of(d)) - 64'd1;
          chk("done_dut", 64'(d), 64'(e.d));
          chk($sformatf("chain%0d", d), chain_m[d] & mask, e.chain);
          chk($sformatf("en_cycles%0d", d), 64'(en_cnt[d]), 64'(e.en));
          chk($sformatf("latency%0d", d), 64'(lat_cnt[d] + 1), 64'(e.lat));
        end
      end else if (!busy_s[d]) begin
        en_cnt[d]  = 0;
        lat_cnt[d] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
  endtask

  task automatic wait_ready(input int d, output bit ok);
    int n = 0;
    while (!ready_s[d] && n < 200) begin
      tick();
      n++;
    end
    ok = ready_s[d];
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout%0d: got word_ready=0, expected 1 within 200 cycles", d);
    end
  endtask

  task automatic feed(input int d, input logic [7:0] w);
    valid_s[d] = 1'b1;
    win_s[d]   = w;
    tick();
    valid_s[d] = 1'b0;
    win_s[d]   = 8'($urandom);
  endtask

  // Full load of nw words from wbuf with smin..smax stall cycles per word.
  // poke pulses start once during SHIFT and once during DONE.
  task automatic do_load(input int d, input int nw, input int smin, input int smax,
                         input bit poke);
    int   st [8];
    int   tot = 0;
    int   n;
    bit   ok;
    exp_t e;
    for (int i = 0; i < nw; i++) begin
      st[i] = int'($urandom_range(smax, smin));
      tot += st[i];
    end
    e.d     = d;
    e.chain = ref_chain(cl_of(d), nw);
    e.en    = cl_of(d);
    e.lat   = nw + cl_of(d) + 1 + tot;
    exp_q.push_back(e);
    pulse_start(d);
    for (int i = 0; i < nw; i++) begin
      wait_ready(d, ok);
      if (!ok) return;
      repeat (st[i]) tick();
      feed(d, wbuf[i]);
      if (poke && i == 0) pulse_start(d);
    end
    if (poke) begin
      n = 0;
      while (!done_s[d] && n < 200) begin
        tick();
        n++;
      end
      if (done_s[d]) pulse_start(d);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk($sformatf("load_completed%0d", d), 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
    chk($sformatf("idle_after_load%0d", d), 64'(busy_s[d]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    for (int d = 0; d < 2; d++) begin
      chain_m[d] = '0;
      en_cnt[d]  = 0;
      lat_cnt[d] = 0;
      win_s[d]   = 8'hFF;
    end
    nrst    = 1'b0;
    start_s = 2'b11;
    abort_s = 2'b00;
    valid_s = 2'b11;
    repeat (3) tick();
    chk("rst_en", 64'(en_s), 64'd0);
    chk("rst_dout", 64'(dout_s), 64'd0);
    chk("rst_ready", 64'(ready_s), 64'd0);
    chk("rst_busy", 64'(busy_s), 64'd0);
    chk("rst_done", 64'(done_s), 64'd0);
    start_s = 2'b00;
    valid_s = 2'b00;
    nrst    = 1'b1;
    repeat (4) tick();
    chk("post_rst_en", 64'(en_s), 64'd0);
    chk("post_rst_busy", 64'(busy_s), 64'd0);

    // Directed vector on the 48-bit chain, no stalls then 5-cycle stalls.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C; wbuf[2] = 8'hFF;
    wbuf[3] = 8'h00; wbuf[4] = 8'h81; wbuf[5] = 8'h7E;
    do_load(0, 6, 0, 0, 1'b0);
    chk("chain_A53CFF00817E", chain_m[0] & 64'hFFFF_FFFF_FFFF, 64'hA53C_FF00_817E);
    do_load(0, 6, 5, 5, 1'b0);

    // Partial final word on the 12-bit chain.
    wbuf[0] = 8'hC3; wbuf[1] = 8'h9F;
    do_load(1, 2, 0, 0, 1'b0);
    chk("chain_C39", chain_m[1] & 64'hFFF, 64'hC39);

    // start during SHIFT and DONE is ignored.
    for (int i = 0; i < 6; i++) wbuf[i] = 8'($urandom);
    do_load(0, 6, 0, 1, 1'b1);

    // Abort in the 3rd SHIFT cycle of word 2.
    pulse_start(0);
    feed(0, 8'h5A);
    wait_ready(0, ok);
    feed(0, 8'hC7);
    tick();
    tick();
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    chk("abort_en", 64'(en_s[0]), 64'd0);
    chk("abort_busy", 64'(busy_s[0]), 64'd0);
    chk("abort_done", 64'(done_s[0]), 64'd0);
    // abort with start in IDLE stays in IDLE.
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    repeat (2) tick();
    chk("abort_start_idle", 64'(busy_s[0]), 64'd0);
    for (int i = 0; i < 6; i++) wbuf[i] = 8'($urandom);
    do_load(0, 6, 0, 2, 1'b0);

    // Asynchronous reset in the middle of a shift.
    pulse_start(0);
    feed(0, 8'hF0);
    tick();
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_en", 64'(en_s[0]), 64'd0);
    chk("async_rst_busy", 64'(busy_s[0]), 64'd0);
    tick();
    nrst = 1'b1;
    repeat (3) tick();
    chk("after_async_rst_en", 64'(en_s[0]), 64'd0);

    // Randomized loads on both chains.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 6; i++) wbuf[i] = 8'($urandom);
      do_load(0, 6, 0, 3, 1'b0);
      for (int i = 0; i < 2; i++) wbuf[i] = 8'($urandom);
      do_load(1, 2, 0, 3, 1'b0);
    end

    repeat (5) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
